// File: rtl/shift_ext_pkg.sv
// Shared encodings for the shift/extend pipe.
// Holds the in_t encodings for both modes, the legal WIDTH/AMT_W values,
// the internal operation enum and the decoder from (in_e, in_t) to it.
package shift_ext_pkg;

  localparam int unsigned WIDTH_NARROW = 32;
  localparam int unsigned WIDTH_WIDE   = 64;
  localparam int unsigned AMT_W_MIN    = 6;
  localparam int unsigned AMT_W_MAX    = 8;
  localparam int unsigned T_W          = 3;

  // in_t encodings with in_e = 0 (shift/rotate)
  localparam logic [T_W-1:0] T_LSL   = 3'd0;
  localparam logic [T_W-1:0] T_LSR   = 3'd1;
  localparam logic [T_W-1:0] T_ASR   = 3'd2;
  localparam logic [T_W-1:0] T_ROR   = 3'd3;
  localparam logic [T_W-1:0] T_ROR2  = 3'd4;
  localparam logic [T_W-1:0] T_RRX   = 3'd5;
  localparam logic [T_W-1:0] T_LSL2  = 3'd6;
  localparam logic [T_W-1:0] T_LSL24 = 3'd7;

  // in_t encodings with in_e = 1 (extend); 6 and 7 are illegal
  localparam logic [T_W-1:0] T_SXTB  = 3'd0;
  localparam logic [T_W-1:0] T_UXTB  = 3'd1;
  localparam logic [T_W-1:0] T_SXTH  = 3'd2;
  localparam logic [T_W-1:0] T_UXTH  = 3'd3;
  localparam logic [T_W-1:0] T_SXT24 = 3'd4;
  localparam logic [T_W-1:0] T_UXT12 = 3'd5;

  typedef enum logic [3:0] {
    OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_ROR2, OP_RRX, OP_LSL2, OP_LSL24,
    OP_SXTB, OP_UXTB, OP_SXTH, OP_UXTH, OP_SXT24, OP_UXT12, OP_ERR
  } op_e;

  function automatic logic width_legal(input int unsigned w);
    return (w == WIDTH_NARROW) || (w == WIDTH_WIDE);
  endfunction

  function automatic logic amt_w_legal(input int unsigned w);
    return (w >= AMT_W_MIN) && (w <= AMT_W_MAX);
  endfunction

  // Collapse mode + select into one flat operation code for stage 2
  function automatic op_e decode_op(input logic e, input logic [T_W-1:0] t);
    op_e op;
    op = OP_ERR;
    if (!e) begin
      case (t)
        T_LSL:   op = OP_LSL;
        T_LSR:   op = OP_LSR;
        T_ASR:   op = OP_ASR;
        T_ROR:   op = OP_ROR;
        T_ROR2:  op = OP_ROR2;
        T_RRX:   op = OP_RRX;
        T_LSL2:  op = OP_LSL2;
        default: op = OP_LSL24;
      endcase
    end else begin
      case (t)
        T_SXTB:  op = OP_SXTB;
        T_UXTB:  op = OP_UXTB;
        T_SXTH:  op = OP_SXTH;
        T_UXTH:  op = OP_UXTH;
        T_SXT24: op = OP_SXT24;
        T_UXT12: op = OP_UXT12;
        default: op = OP_ERR;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/shift_extend_pipe_if.sv
// Request/response bundle of the shift/extend pipe.
// master: producer of requests and consumer of results (drives in_*, out_ready).
// slave : the pipe (drives in_ready, out_valid, out_data, out_cout, out_err).
interface shift_extend_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_t;
  logic             in_e;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_amt, in_t, in_e, in_cin, out_ready,
    input  in_ready, out_valid, out_data, out_cout, out_err
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_t, in_e, in_cin, out_ready,
    output in_ready, out_valid, out_data, out_cout, out_err
  );

endinterface

// File: rtl/shift_ext_core.sv
// Stateless stage-2 compute of the shift/extend pipe.
// Ports: data/amt/cin/op  - decoded stage-1 operands
//        res_c/cout_c/err_c - combinational result, carry out, illegal-op flag
module shift_ext_core
  import shift_ext_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic             cin,
  input  op_e              op,
  output logic [WIDTH-1:0] res_c,
  output logic             cout_c,
  output logic             err_c
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [31:0]      amt_x;
  logic             amt_zero;
  logic             amt_le_w;
  logic             amt_ge_w;
  logic [SH_W-1:0]  rot_amt;
  logic [SH_W-1:0]  rot2_amt;
  logic [WIDTH:0]   lsl_w;
  logic [WIDTH:0]   lsr_w;
  logic [WIDTH:0]   asr_w;
  logic [WIDTH-1:0] ror_r;
  logic [WIDTH-1:0] ror2_r;

  // Rotate right; a zero amount makes the left shift go fully out of range
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] d,
                                            input logic [SH_W-1:0] sh);
    return (d >> sh) | (d << (32'(WIDTH) - 32'(sh)));
  endfunction

  // Amount range checks on the full zero-extended amount
  always_comb begin
    amt_x    = 32'(amt);
    amt_zero = (amt_x == 32'd0);
    amt_le_w = (amt_x <= 32'(WIDTH));
    amt_ge_w = (amt_x >= 32'(WIDTH));
    rot_amt  = amt[SH_W-1:0];
    rot2_amt = {amt[SH_W-2:0], 1'b0};
  end

  // One guard bit on the side bits fall out of captures the carry for free
  always_comb begin
    lsl_w  = {1'b0, data} << amt_x;
    lsr_w  = {data, 1'b0} >> amt_x;
    asr_w  = $signed({data, 1'b0}) >>> amt_x;
    ror_r  = rotr(data, rot_amt);
    ror2_r = rotr(data, rot2_amt);
  end

  // Result select
  always_comb begin
    res_c  = '0;
    cout_c = cin;
    err_c  = 1'b0;
    case (op)
      OP_LSL: begin
        if (amt_zero) begin
          res_c = data;
        end else if (amt_le_w) begin
          res_c  = lsl_w[WIDTH-1:0];
          cout_c = lsl_w[WIDTH];
        end else begin
          cout_c = 1'b0;
        end
      end
      OP_LSR: begin
        if (amt_zero) begin
          res_c = data;
        end else if (amt_le_w) begin
          res_c  = lsr_w[WIDTH:1];
          cout_c = lsr_w[0];
        end else begin
          cout_c = 1'b0;
        end
      end
      OP_ASR: begin
        if (amt_zero) begin
          res_c = data;
        end else if (amt_ge_w) begin
          res_c  = {WIDTH{data[WIDTH-1]}};
          cout_c = data[WIDTH-1];
        end else begin
          res_c  = asr_w[WIDTH:1];
          cout_c = asr_w[0];
        end
      end
      OP_ROR: begin
        res_c = ror_r;
        if (!amt_zero) cout_c = ror_r[WIDTH-1];
      end
      OP_ROR2: begin
        res_c = ror2_r;
        if (!amt_zero) cout_c = ror2_r[WIDTH-1];
      end
      OP_RRX: begin
        res_c  = {cin, data[WIDTH-1:1]};
        cout_c = data[0];
      end
      OP_LSL2: begin
        res_c  = {data[WIDTH-3:0], 2'b00};
        cout_c = data[WIDTH-2];
      end
      OP_LSL24: begin
        res_c  = {data[WIDTH-25:0], 24'd0};
        cout_c = data[WIDTH-24];
      end
      OP_SXTB:  res_c = {{(WIDTH-8){data[7]}}, data[7:0]};
      OP_UXTB:  res_c = {{(WIDTH-8){1'b0}}, data[7:0]};
      OP_SXTH:  res_c = {{(WIDTH-16){data[15]}}, data[15:0]};
      OP_UXTH:  res_c = {{(WIDTH-16){1'b0}}, data[15:0]};
      OP_SXT24: res_c = {{(WIDTH-24){data[23]}}, data[23:0]};
      OP_UXT12: res_c = {{(WIDTH-12){1'b0}}, data[11:0]};
      default:  err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_extend_pipe.sv
// Two-stage shift/rotate/extend unit with valid/ready flow control.
// Stage 1 registers the operands and the decoded operation; stage 2 registers
// the result of shift_ext_core. One result per cycle, stalls under back-pressure.
// Ports: clk, reset (synchronous, active-high), bus (slave side of
//        shift_extend_pipe_if: request in_*, result out_*).
module shift_extend_pipe
  import shift_ext_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 8
) (
  input logic               clk,
  input logic               reset,
  shift_extend_pipe_if.slave bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [AMT_W-1:0] s1_amt;
  logic             s1_cin;
  op_e              s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_cout;
  logic             s2_err;

  logic             s1_load_c;
  logic             s2_load_c;
  logic [WIDTH-1:0] core_res_c;
  logic             core_cout_c;
  logic             core_err_c;

  // A stage advances when it is empty or its successor advances
  assign s2_load_c = !s2_valid || bus.out_ready;
  assign s1_load_c = !s1_valid || s2_load_c;

  // Pipeline registers; reset wins over any transfer in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_amt   <= '0;
      s1_cin   <= 1'b0;
      s1_op    <= OP_LSL;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_cout  <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      if (s1_load_c) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
          s1_amt  <= bus.in_amt;
          s1_cin  <= bus.in_cin;
          s1_op   <= decode_op(bus.in_e, bus.in_t);
        end
      end
      if (s2_load_c) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= core_res_c;
          s2_cout <= core_cout_c;
          s2_err  <= core_err_c;
        end
      end
    end
  end

  shift_ext_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_core (
    .data   (s1_data),
    .amt    (s1_amt),
    .cin    (s1_cin),
    .op     (s1_op),
    .res_c  (core_res_c),
    .cout_c (core_cout_c),
    .err_c  (core_err_c)
  );

  assign bus.in_ready  = s1_load_c;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_cout  = s2_cout;
  assign bus.out_err   = s2_err;

endmodule

// File: tb/tb_shift_extend_pipe.sv
// Scoreboard bench for shift_extend_pipe: directed vectors, back-pressure,
// randomized traffic against a bit-level reference model, mid-stream reset.
module tb_shift_extend_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_extend_pipe_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  shift_extend_pipe #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         e;
    int           acc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic [2:0]    t;
    logic          e;
    logic          c;
    bit            has_exp;
    logic [W-1:0]  xd;
    logic          xc;
    logic          xe;
    bit            lat;
  } req_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int received = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: each result bit is picked straight from the rule text
  function automatic void model(input logic [W-1:0] d, input int unsigned amt,
                                input int unsigned t, input bit e, input bit cin,
                                output logic [W-1:0] r, output logic co, output logic er);
    int unsigned k;
    int unsigned n;
    bit sg;
    r = '0; co = cin; er = 1'b0;
    if (!e) begin
      case (t)
        0: if (amt == 0) r = d;
           else begin
             for (int i = 0; i < W; i++) if (i >= amt) r[i] = d[i - amt];
             co = (amt <= W) ? d[W - amt] : 1'b0;
           end
        1: if (amt == 0) r = d;
           else begin
             for (int i = 0; i < W; i++) if (i + amt < W) r[i] = d[i + amt];
             co = (amt <= W) ? d[amt - 1] : 1'b0;
           end
        2: if (amt == 0) r = d;
           else begin
             for (int i = 0; i < W; i++) r[i] = (i + amt < W) ? d[i + amt] : d[W-1];
             co = (amt >= W) ? d[W-1] : d[amt - 1];
           end
        3, 4: begin
          k = ((t == 3) ? amt : 2 * amt) % W;
          for (int i = 0; i < W; i++) r[i] = d[(i + k) % W];
          co = (amt == 0) ? cin : r[W-1];
        end
        5: begin
          for (int i = 0; i < W - 1; i++) r[i] = d[i + 1];
          r[W-1] = cin;
          co = d[0];
        end
        default: begin
          k = (t == 6) ? 2 : 24;
          for (int i = 0; i < W; i++) if (i >= k) r[i] = d[i - k];
          co = d[W - k];
        end
      endcase
    end else if (t >= 6) begin
      er = 1'b1;
    end else begin
      case (t)
        0, 1: n = 8;
        2, 3: n = 16;
        4: n = 24;
        default: n = 12;
      endcase
      sg = (t == 0) || (t == 2) || (t == 4);
      for (int i = 0; i < W; i++) r[i] = (i < n) ? d[i] : (sg ? d[n-1] : 1'b0);
    end
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int unsigned a;
    case ($urandom_range(0, 5))
      0: a = 0;
      1: a = 1;
      2: a = W - 1;
      3: a = W;
      4: a = W + 1;
      default: a = $urandom_range(0, 255);
    endcase
    r.d = $urandom; r.a = AW'(a); r.t = 3'($urandom_range(0, 7));
    r.e = ($urandom_range(0, 3) == 0); r.c = 1'($urandom_range(0, 1));
    r.has_exp = 0; r.xd = '0; r.xc = 0; r.xe = 0; r.lat = 0;
    return r;
  endfunction

  function automatic req_t dir_req(input logic e, input logic [2:0] t, input logic [W-1:0] d,
                                   input int unsigned a, input logic c,
                                   input logic [W-1:0] xd, input logic xc, input logic xe);
    req_t r;
    r.d = d; r.a = AW'(a); r.t = t; r.e = e; r.c = c;
    r.has_exp = 1; r.xd = xd; r.xc = xc; r.xe = xe; r.lat = 1;
    return r;
  endfunction

  // One cycle: drive after the falling edge, sample just before the rising edge
  task automatic drive_cycle(input req_t r, input bit v, output bit acc);
    exp_t x;
    @(negedge clk); #1;
    bus.in_valid = v; bus.in_data = r.d; bus.in_amt = r.a;
    bus.in_t = r.t; bus.in_e = r.e; bus.in_cin = r.c;
    #3;
    acc = v && bus.in_ready && !reset;
    if (acc) begin
      if (r.has_exp) begin
        x.d = r.xd; x.c = r.xc; x.e = r.xe;
      end else begin
        model(r.d, 32'(r.a), 32'(r.t), r.e, r.c, x.d, x.c, x.e);
      end
      x.acc = cyc; x.lat = r.lat;
      sb.push_back(x);
    end
  endtask

  task automatic send(input req_t r);
    bit acc;
    int n;
    n = 0;
    do begin
      drive_cycle(r, 1'b1, acc);
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    req_t r;
    r = rand_req();
    repeat (n) drive_cycle(r, 1'b0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      idle(1);
      n++;
    end
  endtask

  // Consumer ready generator
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each output transfer, checks hold stability
  exp_t mon_e;
  bit held = 0;
  logic [63:0] held_val;
  initial begin
    forever begin
      @(negedge clk); #4;
      if (reset) begin
        held = 0;
        continue;
      end
      if (held) begin
        check_val("hold_valid", 64'(bus.out_valid), 64'd1);
        check_val("hold_data", 64'({bus.out_data, bus.out_cout, bus.out_err}), held_val);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out actual=%0h required=no_output", bus.out_data);
        end else begin
          mon_e = sb.pop_front();
          check_val("result", 64'({bus.out_data, bus.out_cout, bus.out_err}),
                    64'({mon_e.d, mon_e.c, mon_e.e}));
          if (mon_e.lat) check_val("latency", 64'(cyc - mon_e.acc), 64'd2);
          received++;
        end
      end
      held = bus.out_valid && !bus.out_ready;
      held_val = 64'({bus.out_data, bus.out_cout, bus.out_err});
    end
  end

  initial begin
    req_t q[$];
    req_t r;
    bit acc;
    logic [3:0] ir;
    int c;
    int r0;

    reset = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.in_amt = '0;
    bus.in_t = '0; bus.in_e = 0; bus.in_cin = 0;
    repeat (3) @(negedge clk);
    #4;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_data", 64'(bus.out_data), 64'd0);
    check_val("rst_out_cout", 64'(bus.out_cout), 64'd0);
    check_val("rst_out_err", 64'(bus.out_err), 64'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    #3;
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vectors with literal expectations, pipeline empty, ready high
    q.push_back(dir_req(0, 3'd0, 32'h8000_0001, 1,  0, 32'h0000_0002, 1, 0));
    q.push_back(dir_req(0, 3'd1, 32'h8000_0000, 32, 0, 32'h0000_0000, 1, 0));
    q.push_back(dir_req(0, 3'd1, 32'h8000_0000, 33, 0, 32'h0000_0000, 0, 0));
    q.push_back(dir_req(0, 3'd3, 32'h0000_00F1, 36, 0, 32'h1000_000F, 0, 0));
    q.push_back(dir_req(0, 3'd5, 32'h0000_0003, 0,  1, 32'h8000_0001, 1, 0));
    q.push_back(dir_req(1, 3'd0, 32'h0000_0080, 0,  0, 32'hFFFF_FF80, 0, 0));
    q.push_back(dir_req(1, 3'd7, 32'h1234_5678, 0,  1, 32'h0000_0000, 1, 1));
    while (q.size() != 0) begin
      send(q.pop_front());
      idle(3);
    end
    drain();

    // Back-pressure: consumer stalls for 4 cycles while 6 requests stream in
    for (int i = 0; i < 6; i++) q.push_back(rand_req());
    r0 = received;
    rdy_mode = 2;
    c = 0;
    ir = '0;
    while (q.size() != 0 && c < 100) begin
      drive_cycle(q[0], 1'b1, acc);
      if (c < 4) ir[3-c] = acc;
      if (acc) void'(q.pop_front());
      c++;
      if (c == 4) rdy_mode = 0;
    end
    check_val("bp_in_ready", 64'(ir), 64'hC);
    idle(1);
    drain();
    check_val("bp_count", 64'(received - r0), 64'd6);

    // Random traffic with random consumer stalls
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(rand_req());
    end
    rdy_mode = 0;
    idle(1);
    drain();

    // Reset with two requests held in the pipe
    rdy_mode = 2;
    send(rand_req());
    send(rand_req());
    @(negedge clk); #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    rdy_mode = 0;
    #3;
    check_val("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    idle(6);
    send(dir_req(0, 3'd0, 32'h8000_0001, 1, 0, 32'h0000_0002, 1, 0));
    idle(1);
    drain();
    idle(3);
    check_val("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
